dbg_mem_xfer_engine: RTL and testbench

Synthesizable successor to the simulation-only BRAM load/dump sequencing. It moves word streams into, or out of, any of NUM_CH memories through their debug second ports (A2/WD2/WE2/RD2). It holds the core in reset while a transfer runs. It sits between a host link (UART/JTAG bridge) and RV32ICore's instruction and data cache debug ports.

---
 rtl/dbg_mem_xfer_engine.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_dbg_mem_xfer_engine.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_mem_xfer_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_mem_xfer_engine
//  Purpose  : Moves 32-bit word streams into (load) or out of (dump) one of
//             NUM_CH memories through their debug second ports
//             (A2/WD2/WE2/RD2). The CPU core is held in reset while a
//             transfer is in progress.
//  Ports    :
//    CPU_CLK, CPU_RST        clock, asynchronous active-high reset
//    cmd_valid/cmd_ready     command handshake (ready only while idle)
//    cmd_op                  0 = load (host->memory), 1 = dump (memory->host)
//    cmd_ch, cmd_base,       target channel, byte base address, word count
//    cmd_words
//    in_valid/in_ready/      load data stream
//    in_data
//    out_valid/out_ready/    dump data stream
//    out_data
//    abort                   synchronous cancel of the running transfer
//    dbg_a2/dbg_wd2/dbg_we2  per-channel debug port drive (channel k at
//                            slice k)
//    dbg_rd2                 per-channel debug port read data
//    core_hold               core reset request
//    busy, done, err         status (done = 1-cycle pulse, err = sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module dbg_mem_xfer_engine #(
  parameter int NUM_CH      = 2,
  parameter int DEPTH_WORDS = 4096,
  parameter int RD_LAT      = 1,
  parameter int CNT_W       = 13,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [CH_W-1:0]       cmd_ch,
  input  logic [31:0]           cmd_base,
  input  logic [CNT_W-1:0]      cmd_words,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  input  logic                  abort,
  output logic [NUM_CH*32-1:0]  dbg_a2,
  output logic [NUM_CH*32-1:0]  dbg_wd2,
  output logic [NUM_CH*4-1:0]   dbg_we2,
  input  logic [NUM_CH*32-1:0]  dbg_rd2,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_OUT   = 3'd4,
    FINISH   = 3'd5
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

  state_t             state, state_nxt;
  logic [CH_W-1:0]    ch_q;
  logic [CNT_W-1:0]   words_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [31:0]        addr_q;      // address of the next word to move
  logic [31:0]        a2_q;
  logic [31:0]        wd2_q;
  logic [3:0]         we2_q;
  logic [2:0]         lat_cnt;
  logic [31:0]        rd2_sel;
  logic [31:0]        base_word;

  logic               ch_bad;
  logic               range_bad;
  logic [32:0]        span;
  logic               accept_ok;
  logic               reject;
  logic               load_fire;
  logic               out_fire;
  logic               last_word;
  logic               abort_hit;

  // Byte-lane bits of the base address carry no meaning.
  logic               unused_base_lsbs;
  assign unused_base_lsbs = ^cmd_base[1:0];

  assign base_word = {cmd_base[31:2], 2'b00};
  assign cnt_inc   = cnt + CNT_W'(1);
  assign last_word = (cnt_inc == words_q);

  // Range check on the word index; 33 bits so the sum can never wrap.
  assign span      = 33'(cmd_base[31:2]) + 33'(cmd_words);
  assign range_bad = (span > 33'(DEPTH_WORDS));
  assign ch_bad    = (32'(cmd_ch) >= 32'(NUM_CH));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake decode. abort suppresses every handshake in the
  // cycle it is seen, so a word offered alongside abort is never consumed.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    accept_ok = 1'b0;
    reject    = 1'b0;
    load_fire = 1'b0;
    out_fire  = 1'b0;
    abort_hit = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (ch_bad || range_bad) begin
            reject = 1'b1;
          end else begin
            accept_ok = 1'b1;
            if (cmd_words == '0) begin
              state_nxt = FINISH;
            end else if (cmd_op) begin
              state_nxt = RD_ISSUE;
            end else begin
              state_nxt = LOAD;
            end
          end
        end
      end

      LOAD: begin
        in_ready  = !abort;
        load_fire = in_valid && !abort;
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else if (load_fire && last_word) begin
          state_nxt = FINISH;
        end
      end

      RD_ISSUE: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else if (lat_cnt == LAT_LAST) begin
          state_nxt = RD_OUT;
        end
      end

      RD_OUT: begin
        out_valid = !abort;
        out_fire  = out_ready && !abort;
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else if (out_fire) begin
          state_nxt = last_word ? FINISH : RD_ISSUE;
        end
      end

      FINISH: begin
        done      = !abort;
        abort_hit = abort;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // Asserted combinationally in the accept cycle so the core is stopped
  // before the first debug-port access.
  assign core_hold = (state != IDLE) || accept_ok;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      ch_q     <= '0;
      words_q  <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      a2_q     <= '0;
      wd2_q    <= '0;
      we2_q    <= '0;
      lat_cnt  <= '0;
      out_data <= '0;
      err      <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted word.
      we2_q <= 4'b0000;

      if (accept_ok) begin
        ch_q    <= cmd_ch;
        words_q <= cmd_words;
        cnt     <= '0;
        addr_q  <= base_word;
        if (state_nxt == RD_ISSUE) begin
          a2_q   <= base_word;
          addr_q <= base_word + 32'd4;
        end
      end

      if (load_fire) begin
        a2_q   <= addr_q;
        wd2_q  <= in_data;
        we2_q  <= 4'b1111;
        addr_q <= addr_q + 32'd4;
        cnt    <= cnt_inc;
      end

      if (state == RD_ISSUE) begin
        lat_cnt <= 3'd1;
      end else if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt + 3'd1;
        if (lat_cnt == LAT_LAST) begin
          out_data <= rd2_sel;
        end
      end

      if (out_fire) begin
        cnt <= cnt_inc;
        if (state_nxt == RD_ISSUE) begin
          a2_q   <= addr_q;
          addr_q <= addr_q + 32'd4;
        end
      end

      // Leaving a transfer (normal end or abort) parks the debug port.
      if ((state != IDLE) && (state_nxt == IDLE)) begin
        a2_q  <= '0;
        wd2_q <= '0;
      end

      if (reject || abort_hit) begin
        err <= 1'b1;
      end else if (accept_ok) begin
        err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel fan-out: only the selected channel sees the registered drive.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic sel;
    assign sel = (ch_q == CH_W'(k));
    assign dbg_a2[32*k +: 32]  = sel ? a2_q  : 32'd0;
    assign dbg_wd2[32*k +: 32] = sel ? wd2_q : 32'd0;
    assign dbg_we2[4*k +: 4]   = sel ? we2_q : 4'd0;
  end

  always_comb begin
    rd2_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        rd2_sel = dbg_rd2[32*k +: 32];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbg_mem_xfer_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbg_mem_xfer_engine
//  Purpose  : Directed self-checking bench for dbg_mem_xfer_engine with three
//             channels so that an out-of-range channel number is expressible.
//             Each channel is backed by a 64-word memory model with one
//             cycle of read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_mem_xfer_engine;

  localparam int NCH = 3;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [1:0]        cmd_ch;
  logic [31:0]       cmd_base;
  logic [12:0]       cmd_words;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic              abort;
  logic [NCH*32-1:0] dbg_a2;
  logic [NCH*32-1:0] dbg_wd2;
  logic [NCH*4-1:0]  dbg_we2;
  logic [NCH*32-1:0] rd2_bus;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [NCH][64];

  dbg_mem_xfer_engine #(
    .NUM_CH(NCH), .DEPTH_WORDS(4096), .RD_LAT(1), .CNT_W(13)
  ) dut (
    .CPU_CLK(clk), .CPU_RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_base(cmd_base), .cmd_words(cmd_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .abort(abort),
    .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(rd2_bus),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int c, input int i);
    return 32'hC0DE_0000 + 32'(c * 256) + 32'(i);
  endfunction

  // Memory model: reset fills a known pattern; full-word writes; RD2 one
  // cycle after A2.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < 64; i++) mem[c][i] <= pat(c, i);
      end
      rd2_bus <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (dbg_we2[4*c +: 4] == 4'hF) mem[c][dbg_a2[32*c+2 +: 6]] <= dbg_wd2[32*c +: 32];
        rd2_bus[32*c +: 32] <= mem[c][dbg_a2[32*c+2 +: 6]];
      end
    end
  end

  function automatic logic [31:0] a2_of(input int c);
    return dbg_a2[32*c +: 32];
  endfunction
  function automatic logic [31:0] wd2_of(input int c);
    return dbg_wd2[32*c +: 32];
  endfunction
  function automatic logic [3:0] we2_of(input int c);
    return dbg_we2[4*c +: 4];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [1:0] ch,
                          input logic [31:0] base, input logic [12:0] words);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_base  = base;
    cmd_words = words;
    #1;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  logic [31:0] d1 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] held;

    rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_ch = 0; cmd_base = 0; cmd_words = 0;
    in_valid = 0; in_data = 0; out_ready = 0; abort = 0;
    #3;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_core_hold", core_hold, 0);
    check("rst_dbg_zero", {63'd0, |{dbg_a2, dbg_wd2, dbg_we2}}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_done", {err, done, in_ready}, 0);
    @(posedge clk); #1; rst = 1'b0;
    step();

    // ---- 1: load ch1, 4 words, in_valid always high
    send_cmd(0, 2'd1, 32'h0, 13'd4);
    check("t1_hold_accept", core_hold, 1);
    step();
    cmd_valid = 0;
    in_valid  = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = d1[k];
      #1;
      check("t1_in_ready", in_ready, 1);
      check("t1_hold", core_hold, 1);
      if (k > 0) begin
        check("t1_we2", we2_of(1), 4'hF);
        check("t1_a2", a2_of(1), 32'(4 * (k - 1)));
        check("t1_wd2", wd2_of(1), d1[k-1]);
        check("t1_ch0_quiet", {a2_of(0), 28'd0, we2_of(0)}, 0);
      end else begin
        check("t1_we2_first", we2_of(1), 4'h0);
      end
      step();
    end
    in_valid = 0;
    #1;
    check("t1_done", done, 1);
    check("t1_in_ready_fin", in_ready, 0);
    check("t1_we2_last", we2_of(1), 4'hF);
    check("t1_a2_last", a2_of(1), 32'hC);
    check("t1_wd2_last", wd2_of(1), 32'h44444444);
    check("t1_hold_fin", core_hold, 1);
    step();
    check("t1_done_off", done, 0);
    check("t1_hold_off", core_hold, 0);
    check("t1_we2_off", {60'd0, we2_of(1)}, 0);
    for (int k = 0; k < 4; k++) check("t1_mem", mem[1][k], d1[k]);

    // ---- 2: dump ch0, base 0x10, 3 words, stalled handshakes
    send_cmd(1, 2'd0, 32'h10, 13'd3);
    step();
    cmd_valid = 0;
    out_ready = 0;
    for (int j = 0; j < 3; j++) begin
      wait_out_valid(n);
      check("t2_latency", n, 2);
      check("t2_data", out_data, pat(0, 4 + j));
      check("t2_a2", a2_of(0), 32'(32'h10 + 4 * j));
      check("t2_no_we2", {52'd0, dbg_we2}, 0);
      held = out_data;
      step();
      check("t2_valid_stall", out_valid, 1);
      check("t2_data_stall", out_data, held);
      check("t2_a2_stall", a2_of(0), 32'(32'h10 + 4 * j));
      out_ready = 1;
      step();
      out_ready = 0;
      check("t2_valid_drop", out_valid, 0);
      if (j < 2) check("t2_a2_next", a2_of(0), 32'(32'h10 + 4 * (j + 1)));
      else       check("t2_done", done, 1);
    end
    step();
    check("t2_idle", busy, 0);

    // ---- 3: rejected commands, then a valid one at the top boundary
    send_cmd(0, 2'd3, 32'h0, 13'd1);
    check("t3_hold_rej", core_hold, 0);
    step();
    cmd_valid = 0;
    check("t3_err_ch", err, 1);
    check("t3_ready_ch", cmd_ready, 1);
    check("t3_busy_ch", busy, 0);
    send_cmd(0, 2'd0, 32'h3FFC, 13'd2);
    step();
    cmd_valid = 0;
    check("t3_err_range", err, 1);
    check("t3_ready_range", cmd_ready, 1);
    check("t3_no_we2", {52'd0, dbg_we2}, 0);
    step();
    check("t3_no_we2_b", {52'd0, dbg_we2}, 0);
    send_cmd(0, 2'd2, 32'h3FFC, 13'd1);
    check("t3_hold_ok", core_hold, 1);
    step();
    cmd_valid = 0;
    check("t3_err_clear", err, 0);
    check("t3_busy_ok", busy, 1);
    in_valid = 1;
    in_data  = 32'hDEADBEEF;
    step();
    in_valid = 0;
    check("t3_done", done, 1);
    check("t3_we2", we2_of(2), 4'hF);
    check("t3_a2", a2_of(2), 32'h3FFC);
    step();
    check("t3_mem", mem[2][63], 32'hDEADBEEF);

    // ---- 4: zero-word command
    send_cmd(0, 2'd0, 32'h40, 13'd0);
    check("t4_hold_accept", core_hold, 1);
    step();
    cmd_valid = 0;
    check("t4_done", done, 1);
    check("t4_hold_fin", core_hold, 1);
    check("t4_no_we2", {52'd0, dbg_we2}, 0);
    check("t4_in_ready", in_ready, 0);
    step();
    check("t4_done_off", done, 0);
    check("t4_hold_off", core_hold, 0);
    check("t4_ready", cmd_ready, 1);

    // ---- 5: abort on the 3rd word of a 6-word load
    send_cmd(0, 2'd1, 32'h20, 13'd6);
    step();
    cmd_valid = 0;
    in_valid  = 1;
    in_data   = 32'hA0A0A0A0;
    step();
    in_data   = 32'hA1A1A1A1;
    step();
    in_data   = 32'hA2A2A2A2;
    abort     = 1;
    #1;
    check("t5_in_ready_abort", in_ready, 0);
    check("t5_we2_word1", we2_of(1), 4'hF);
    check("t5_a2_word1", a2_of(1), 32'h24);
    check("t5_wd2_word1", wd2_of(1), 32'hA1A1A1A1);
    step();
    abort    = 0;
    in_valid = 0;
    check("t5_idle", busy, 0);
    check("t5_err", err, 1);
    check("t5_no_done", done, 0);
    check("t5_we2_drop", {60'd0, we2_of(1)}, 0);
    step();
    check("t5_no_done_b", done, 0);
    check("t5_mem0", mem[1][8], 32'hA0A0A0A0);
    check("t5_mem1", mem[1][9], 32'hA1A1A1A1);
    check("t5_mem2_untouched", mem[1][10], pat(1, 10));

    // ---- 6: reset mid-dump, then a fresh load
    send_cmd(1, 2'd0, 32'h10, 13'd3);
    step();
    cmd_valid = 0;
    out_ready = 0;
    wait_out_valid(n);
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_a2", a2_of(0), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_dbg", {63'd0, |{dbg_a2, dbg_wd2, dbg_we2}}, 0);
    check("t6_rst_busy", busy, 0);
    @(posedge clk); #1; rst = 1'b0;
    step();
    check("t6_ready", cmd_ready, 1);
    send_cmd(0, 2'd0, 32'h8, 13'd2);
    step();
    cmd_valid = 0;
    in_valid  = 1;
    in_data   = 32'h5A5A0001;
    step();
    in_data   = 32'h5A5A0002;
    step();
    in_valid  = 0;
    check("t6_done", done, 1);
    step();
    check("t6_mem0", mem[0][2], 32'h5A5A0001);
    check("t6_mem1", mem[0][3], 32'h5A5A0002);
    check("t6_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
